// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone B4 classic arbiter with round-robin grant held
// for a whole cyc burst, plus a watchdog that aborts hung slave cycles.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  output logic [1:0]      grant_o,
  output logic [1:0]      state_o
);

  // Handshake: a beat completes in a cycle where wbs_stb_o=1 and the slave
  // raises ack or err; err has priority, and ack/err seen while wbs_stb_o=0
  // are dropped. The grant stays with the owner until its cyc falls.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] TMAX = WDW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_ABORT = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           own_cyc, own_stb;
  logic           fwd_ack, fwd_err;

  assign own_cyc  = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb  = owner_q ? m1_stb_i : m0_stb_i;
  assign m0_dat_o = wbs_dat_i;
  assign m1_dat_o = wbs_dat_i;
  assign state_o  = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = S_GRANT;
          owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
        end
      end
      S_GRANT: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else if (TIMEOUT > 0 && own_stb && !wbs_ack_i && !wbs_err_i) begin
          wd_d = (wd_q == TMAX) ? wd_q : wd_q + WDW'(1);
          if (wd_d == TMAX) state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        // wd_q still holds TMAX on the first abort cycle only; it drives the err pulse.
        if (!own_cyc) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    grant_o   = 2'b00;
    fwd_ack   = 1'b0;
    fwd_err   = 1'b0;
    case (state_q)
      S_GRANT: begin
        wbs_cyc_o = own_cyc;
        wbs_stb_o = own_stb;
        wbs_we_o  = owner_q ? m1_we_i  : m0_we_i;
        wbs_sel_o = owner_q ? m1_sel_i : m0_sel_i;
        wbs_adr_o = owner_q ? m1_adr_i : m0_adr_i;
        wbs_dat_o = owner_q ? m1_dat_i : m0_dat_i;
        grant_o   = owner_q ? 2'b10 : 2'b01;
        fwd_err   = own_stb & wbs_err_i;
        fwd_ack   = own_stb & wbs_ack_i & ~wbs_err_i;
      end
      S_ABORT: begin
        grant_o = owner_q ? 2'b10 : 2'b01;
        fwd_err = (wd_q == TMAX);
      end
      default: ;
    endcase
    m0_ack_o = fwd_ack & ~owner_q;
    m1_ack_o = fwd_ack & owner_q;
    m0_err_o = fwd_err & ~owner_q;
    m1_err_o = fwd_err & owner_q;
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random master/slave traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_wb_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [1:0]    cyc, stb, we;
  logic [SW-1:0] sel [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat [2];
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;

  logic [DW-1:0] m0_dat_o, m1_dat_o, wbs_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [SW-1:0] wbs_sel_o;
  logic [AW-1:0] wbs_adr_o;
  logic [1:0]    grant_o, state_o;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .grant_o(grant_o), .state_o(state_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus (-1 = nobody), whether the owner's
  // cycle was aborted, who finished last, and how long stb has gone unanswered.
  int owner;
  bit aborted, abort_first;
  int last_owner;
  int stall;
  logic [1:0] seen_ack, seen_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; aborted = 0; abort_first = 0; last_owner = 1; stall = 0;
  endtask

  task automatic check_outputs();
    logic e_cyc, e_stb, e_we;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [1:0] e_ack, e_err, e_gnt;
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = '0; e_adr = '0; e_dat = '0;
    e_ack = 2'b00; e_err = 2'b00; e_gnt = 2'b00;
    if (rst_ni && owner >= 0) begin
      e_gnt = (owner == 0) ? 2'b01 : 2'b10;
      if (!aborted) begin
        e_cyc = cyc[owner]; e_stb = stb[owner]; e_we = we[owner];
        e_sel = sel[owner]; e_adr = adr[owner]; e_dat = wdat[owner];
        if (e_stb && s_err) e_err[owner] = 1'b1;
        else if (e_stb && s_ack) e_ack[owner] = 1'b1;
      end else if (abort_first) begin
        e_err[owner] = 1'b1;
      end
    end
    chk("wbs_cyc", 64'(wbs_cyc_o), 64'(e_cyc));
    chk("wbs_stb", 64'(wbs_stb_o), 64'(e_stb));
    chk("wbs_we",  64'(wbs_we_o),  64'(e_we));
    chk("wbs_sel", 64'(wbs_sel_o), 64'(e_sel));
    chk("wbs_adr", 64'(wbs_adr_o), 64'(e_adr));
    chk("wbs_dat", 64'(wbs_dat_o), 64'(e_dat));
    chk("m0_ack",  64'(m0_ack_o),  64'(e_ack[0]));
    chk("m1_ack",  64'(m1_ack_o),  64'(e_ack[1]));
    chk("m0_err",  64'(m0_err_o),  64'(e_err[0]));
    chk("m1_err",  64'(m1_err_o),  64'(e_err[1]));
    chk("grant",   64'(grant_o),   64'(e_gnt));
    if (rst_ni) begin
      chk("m0_dat", 64'(m0_dat_o), 64'(s_dat));
      chk("m1_dat", 64'(m1_dat_o), 64'(s_dat));
    end
    seen_ack = e_ack;
    seen_err = e_err;
  endtask

  task automatic model_edge();
    if (owner < 0) begin
      if (cyc[0] && cyc[1]) owner = (last_owner == 1) ? 0 : 1;
      else if (cyc[0]) owner = 0;
      else if (cyc[1]) owner = 1;
      stall = 0;
    end else if (!aborted) begin
      if (!cyc[owner]) begin
        last_owner = owner; owner = -1; stall = 0;
      end else begin
        if (stb[owner] && !s_ack && !s_err) stall++;
        else stall = 0;
        if (stall == TO) begin aborted = 1; abort_first = 1; end
      end
    end else begin
      abort_first = 0; stall = 0;
      if (!cyc[owner]) begin last_owner = owner; owner = -1; aborted = 0; end
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk_i);
    if (rst_ni) model_edge();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mid_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic quiet();
    cyc = 2'b00; stb = 2'b00; we = 2'b00;
    s_ack = 0; s_err = 0; s_dat = '0;
    for (int m = 0; m < 2; m++) begin sel[m] = '0; adr[m] = '0; wdat[m] = '0; end
  endtask

  task automatic req(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; wdat[m] = d; sel[m] = '1;
  endtask

  task automatic drop(input int m);
    cyc[m] = 1'b0; stb[m] = 1'b0;
  endtask

  task automatic new_txn(input int m);
    we[m] = 1'($urandom_range(0, 1));
    sel[m] = SW'($urandom);
    adr[m] = $urandom;
    wdat[m] = $urandom;
  endtask

  initial begin
    quiet();
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    cycles(3);
    rst_ni = 1'b1;
    cycles(2);

    // single m0 read of 0x100, ack two cycles into the strobe
    req(0, 1'b0, 32'h100, '0);
    cycles(3);
    s_ack = 1; s_dat = 32'hDEADBEEF;
    cycle();
    s_ack = 0; drop(0);
    cycles(3);

    // tie after reset goes to m0; with m0 last, the next tie goes to m1
    mid_reset();
    req(0, 1'b0, 32'h10, '0); req(1, 1'b0, 32'h20, '0);
    cycles(2);
    s_ack = 1; cycle(); s_ack = 0;
    drop(0); drop(1);
    cycles(2);
    req(0, 1'b0, 32'h30, '0); req(1, 1'b0, 32'h40, '0);
    cycles(2);
    s_ack = 1; cycle(); s_ack = 0;
    drop(1);
    cycles(3);
    s_ack = 1; cycle(); s_ack = 0;
    drop(0);
    cycles(2);

    // m1 four-beat write burst while m0 waits
    req(1, 1'b1, 32'h200, 32'hA0);
    cycle();
    req(0, 1'b0, 32'h300, '0);
    for (int b = 0; b < 4; b++) begin
      adr[1] = 32'h200 + 32'(4 * b); wdat[1] = 32'hA0 + 32'(b);
      stb[1] = 1'b1; s_ack = 0; cycle();
      s_ack = 1; cycle();
      stb[1] = 1'b0; s_ack = 0; cycle();
    end
    drop(1);
    cycles(3);
    s_ack = 1; cycle(); s_ack = 0;
    drop(0);
    cycles(2);

    // hung slave: watchdog aborts, owner holds cyc for a while then drops
    req(0, 1'b0, 32'h400, '0);
    cycles(13);
    drop(0);
    cycles(3);

    // ack+err together, then a stray ack with stb low
    req(1, 1'b0, 32'h500, '0);
    cycle();
    s_ack = 1; s_err = 1; cycle();
    s_err = 0; stb[1] = 1'b0; cycle();
    s_ack = 0; drop(1);
    cycles(2);

    // reset in the middle of a transfer, then a tie goes to m0 again
    req(1, 1'b1, 32'h600, 32'h55);
    cycles(2);
    mid_reset();
    quiet();
    cycle();
    req(0, 1'b0, 32'h700, '0); req(1, 1'b0, 32'h710, '0);
    cycles(2);
    s_ack = 1; cycle(); s_ack = 0;
    drop(0); drop(1);
    cycles(2);

    // random traffic with periodic hung-slave windows
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!cyc[m]) begin
          if ($urandom_range(0, 3) == 0) begin cyc[m] = 1'b1; stb[m] = 1'b1; new_txn(m); end
        end else if (seen_ack[m] || seen_err[m]) begin
          if ($urandom_range(0, 1) == 0) drop(m);
          else begin new_txn(m); stb[m] = ($urandom_range(0, 3) != 0); end
        end else if ($urandom_range(0, 40) == 0) begin
          drop(m);
        end else if (!stb[m]) begin
          stb[m] = 1'($urandom_range(0, 1));
        end
      end
      s_dat = $urandom;
      if ((i % 150) < 14) begin
        s_ack = 0; s_err = 0;
      end else begin
        s_ack = ($urandom_range(0, 2) == 0);
        s_err = ($urandom_range(0, 15) == 0);
      end
      if (i == 1700) mid_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
